baseline_discriminator: RTL and testbench
=========================================

BASELINE_DISCRIMINATOR -- requirements
Module: baseline_discriminator

Interface
REQ-001 SHALL have parameter SAMPLEBITS, default 12, ADC sample width.
REQ-002 SHALL have parameter ADDRBITS, default 7, rolling-sum length exponent width; sum width is SAMPLEBITS+ADDRBITS.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port d_in  input  SAMPLEBITS  raw ADC sample, one per clk.
REQ-006 SHALL have port sum_in  input  SAMPLEBITS+ADDRBITS  rolling baseline sum from the rolling-sum block.
REQ-007 SHALL have port sum_valid  input  1  sum_in is a full-length sum.
REQ-008 SHALL have port sum_len_log2  input  3  log2 of the configured sum length.
REQ-009 SHALL have port enable  input  1  discriminator enable.
REQ-010 SHALL have port threshold  input  SAMPLEBITS  unsigned trigger level above baseline.
REQ-011 SHALL have port hyst  input  SAMPLEBITS  unsigned re-arm hysteresis.
REQ-012 SHALL have port holdoff_len  input  16  dead cycles after re-arm condition.
REQ-013 SHALL have port count_clr  input  1  clears trig_count.
REQ-014 SHALL have port trig  output  1  one-cycle trigger pulse; drives the rolling-sum trig input.
REQ-015 SHALL have port baseline  output  SAMPLEBITS  registered baseline estimate.
REQ-016 SHALL have port excess  output  SAMPLEBITS+1  registered signed d_in minus baseline.
REQ-017 SHALL have port armed  output  1  FSM in S_ARMED.
REQ-018 SHALL have port trig_count  output  32  saturating trigger counter.

Function
REQ-019 Stage 1 SHALL register baseline = sum_in >> min(sum_len_log2, ADDRBITS) (truncating) and d_in delayed one cycle.
REQ-020 Stage 2 SHALL register excess = stage-1 sample minus baseline as signed SAMPLEBITS+1 value, no overflow possible.
REQ-021 Stage 1 and stage 2 SHALL register sum_valid alongside the data (qualifier qv).
REQ-022 FSM states SHALL be S_IDLE, S_ARMED, S_HIGH, S_HOLDOFF.
REQ-023 Any state SHALL go to S_IDLE when enable=0 or qv=0; trig SHALL then be 0.
REQ-024 S_IDLE -> S_ARMED when enable=1 and qv=1.
REQ-025 S_ARMED -> S_HIGH when excess > threshold (signed strict compare, threshold zero-extended); trig SHALL be 1 on the following cycle only.
REQ-026 S_HIGH -> exit when excess < threshold - hyst (SAMPLEBITS+2-bit signed compare, negative limits allowed); exit to S_HOLDOFF if holdoff_len != 0, else S_ARMED.
REQ-027 S_HOLDOFF SHALL last exactly holdoff_len cycles, then S_ARMED; holdoff_len sampled on entry.
REQ-028 Latency: sample at d_in in cycle n crossing threshold SHALL give trig=1 in cycle n+3.
REQ-029 Triggers SHALL be at least 2 cycles apart; trig never high in consecutive cycles.
REQ-030 trig_count SHALL increment on each trig, saturate at 0xFFFFFFFF; count_clr SHALL zero it; count_clr with simultaneous trig SHALL yield 1.
REQ-031 Changing sum_len_log2 mid-run SHALL take effect at stage 1 next cycle; no FSM restart beyond sum_valid behaviour.

Reset
REQ-032 rst_n=0 SHALL set FSM S_IDLE, trig 0, baseline 0, excess 0, armed 0, trig_count 0, holdoff counter 0, pipeline qualifiers 0.
REQ-033 Reset mid-S_HIGH or mid-S_HOLDOFF SHALL abort with no trig pulse; first possible trig is 4 cycles after rst_n rises with valid inputs.

Structure
REQ-034 State encodings and stage latency constant (3) SHALL live in the shared discriminator package.
REQ-035 Holdoff counter SHALL reuse the existing pulse_extender sub-module (P_N_WIDTH 16); no other sub-modules.

Verification
REQ-036 Constant d_in=100, sum_in=12800, log2=7, threshold=20 -> baseline=100, excess=0, no trig.
REQ-037 Same, d_in steps to 121 at cycle n -> trig high cycle n+3 only, trig_count=1; 120 -> no trig.
REQ-038 Pulse stays 130 for 10 cycles, hyst=5, holdoff_len=0: no second trig until excess < 15; drop to 110 then rise to 130 -> second trig.
REQ-039 holdoff_len=8: re-cross immediately after fall -> no trig for 8 cycles, trig after S_ARMED resumes.
REQ-040 sum_valid or enable dropped during S_HIGH, rst_n pulsed during S_HOLDOFF -> S_IDLE, no spurious trig, counter cleared by reset.
REQ-041 count_clr asserted on trig cycle -> trig_count=1; force count 0xFFFFFFFF + trig -> stays 0xFFFFFFFF.

Source files
------------

// File: rtl/baseline_discriminator_pkg.sv
// Shared types and constants for the baseline discriminator and its bench.
package baseline_discriminator_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_HIGH    = 2'd2,
      S_HOLDOFF = 2'd3
   } disc_state_t;

   // Cycles from a sample entering d_in to the trig pulse it causes.
   localparam int STAGE_LATENCY = 3;

   localparam int HOLD_WIDTH = 16;

endpackage

// File: rtl/pulse_extender.sv
// Loadable down-counter: start loads len, then counts down to zero one step per clk.
module pulse_extender #(
   parameter int P_N_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 clr,
   input  logic [P_N_WIDTH-1:0] len,
   output logic                 busy,
   output logic                 last
);

   localparam logic [P_N_WIDTH-1:0] ONE = P_N_WIDTH'(1);

   logic [P_N_WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (start) begin
         count_d = len;
      end else if (count_q != '0) begin
         count_d = count_q - ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign busy = (count_q != '0);
   assign last = (count_q == ONE);

endmodule

// File: rtl/baseline_discriminator.sv
// Baseline-subtracting threshold discriminator: two pipeline stages feed a
// trigger FSM with hysteresis re-arm, optional holdoff and a saturating counter.
module baseline_discriminator #(
   parameter int SAMPLEBITS = 12,
   parameter int ADDRBITS   = 7
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [SAMPLEBITS-1:0]        d_in,
   input  logic [SAMPLEBITS+ADDRBITS-1:0] sum_in,
   input  logic                         sum_valid,
   input  logic [2:0]                   sum_len_log2,
   input  logic                         enable,
   input  logic [SAMPLEBITS-1:0]        threshold,
   input  logic [SAMPLEBITS-1:0]        hyst,
   input  logic [15:0]                  holdoff_len,
   input  logic                         count_clr,
   output logic                         trig,
   output logic [SAMPLEBITS-1:0]        baseline,
   output logic [SAMPLEBITS:0]          excess,
   output logic                         armed,
   output logic [31:0]                  trig_count
);

   import baseline_discriminator_pkg::*;

   localparam int SUMBITS = SAMPLEBITS + ADDRBITS;

   logic [SAMPLEBITS-1:0]   baseline_q, baseline_d;
   logic [SAMPLEBITS-1:0]   sample_q, sample_d;
   logic                    s1_qv_q, s1_qv_d;
   logic [SAMPLEBITS:0]     excess_q, excess_d;
   logic                    s2_qv_q, s2_qv_d;
   disc_state_t             state_q, state_d;
   logic                    trig_q, trig_d;
   logic [31:0]             trig_count_q, trig_count_d;

   logic [SUMBITS-1:0]      shifted;
   logic signed [SAMPLEBITS+1:0] excess_ext, lower_lim;
   logic                    above, below;
   logic                    hold_start, hold_clr, hold_busy, hold_last;

   // Stage 1 divides the rolling sum down to a mean; stage 2 subtracts it.
   always_comb begin
      shifted = sum_in >> sum_len_log2;
      if (int'(sum_len_log2) > ADDRBITS) begin
         shifted = sum_in >> ADDRBITS;
      end
      baseline_d = shifted[SAMPLEBITS-1:0];
      sample_d   = d_in;
      s1_qv_d    = sum_valid;
      excess_d   = {1'b0, sample_q} - {1'b0, baseline_q};
      s2_qv_d    = s1_qv_q;
   end

   // Re-arm limit may go negative, hence the extra sign bit.
   assign excess_ext = $signed({excess_q[SAMPLEBITS], excess_q});
   assign lower_lim  = $signed({2'b00, threshold}) - $signed({2'b00, hyst});
   assign above      = $signed(excess_q) > $signed({1'b0, threshold});
   assign below      = excess_ext < lower_lim;

   always_comb begin
      state_d    = state_q;
      trig_d     = 1'b0;
      hold_start = 1'b0;
      hold_clr   = 1'b0;
      if (!enable || !s2_qv_q) begin
         state_d  = S_IDLE;
         hold_clr = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_ARMED;
            S_ARMED: begin
               if (above) begin
                  state_d = S_HIGH;
                  trig_d  = 1'b1;
               end
            end
            S_HIGH: begin
               if (below) begin
                  if (holdoff_len != 16'd0) begin
                     state_d    = S_HOLDOFF;
                     hold_start = 1'b1;
                  end else begin
                     state_d = S_ARMED;
                  end
               end
            end
            S_HOLDOFF: begin
               if (hold_last || !hold_busy) begin
                  state_d = S_ARMED;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // A clear coinciding with a trigger leaves that trigger counted.
   always_comb begin
      trig_count_d = trig_count_q;
      if (count_clr) begin
         trig_count_d = {31'd0, trig_q};
      end else if (trig_q && (trig_count_q != 32'hFFFF_FFFF)) begin
         trig_count_d = trig_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         baseline_q   <= '0;
         sample_q     <= '0;
         s1_qv_q      <= 1'b0;
         excess_q     <= '0;
         s2_qv_q      <= 1'b0;
         state_q      <= S_IDLE;
         trig_q       <= 1'b0;
         trig_count_q <= '0;
      end else begin
         baseline_q   <= baseline_d;
         sample_q     <= sample_d;
         s1_qv_q      <= s1_qv_d;
         excess_q     <= excess_d;
         s2_qv_q      <= s2_qv_d;
         state_q      <= state_d;
         trig_q       <= trig_d;
         trig_count_q <= trig_count_d;
      end
   end

   pulse_extender #(
      .P_N_WIDTH(HOLD_WIDTH)
   ) u_holdoff (
      .clk  (clk),
      .rst_n(rst_n),
      .start(hold_start),
      .clr  (hold_clr),
      .len  (holdoff_len),
      .busy (hold_busy),
      .last (hold_last)
   );

   assign trig       = trig_q;
   assign baseline   = baseline_q;
   assign excess     = excess_q;
   assign armed      = (state_q == S_ARMED);
   assign trig_count = trig_count_q;

endmodule

// File: tb/tb_baseline_discriminator.sv
// Scenario bench for baseline_discriminator; expected trigger cycles are queued
// when stimulus is driven and retired by a trig monitor.
`timescale 1ns/1ps
module tb_baseline_discriminator;

   import baseline_discriminator_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] d_in;
   logic [18:0] sum_in;
   logic        sum_valid;
   logic [2:0]  sum_len_log2;
   logic        enable;
   logic [11:0] threshold;
   logic [11:0] hyst;
   logic [15:0] holdoff_len;
   logic        count_clr;
   logic        trig;
   logic [11:0] baseline;
   logic [12:0] excess;
   logic        armed;
   logic [31:0] trig_count;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int exp_q[$];
   int exp_cyc;
   logic prev_trig = 1'b0;

   baseline_discriminator #(.SAMPLEBITS(12), .ADDRBITS(7)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .d_in        (d_in),
      .sum_in      (sum_in),
      .sum_valid   (sum_valid),
      .sum_len_log2(sum_len_log2),
      .enable      (enable),
      .threshold   (threshold),
      .hyst        (hyst),
      .holdoff_len (holdoff_len),
      .count_clr   (count_clr),
      .trig        (trig),
      .baseline    (baseline),
      .excess      (excess),
      .armed       (armed),
      .trig_count  (trig_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Trigger monitor: every pulse must match the head of the expectation queue.
   always @(negedge clk) begin
      if (trig === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL trig_unexpected: trig=1 at cycle %0d, required no trigger", cyc);
         end else begin
            exp_cyc = exp_q.pop_front();
            if (exp_cyc != cyc) begin
               failures++;
               $display("[TB] FAIL trig_cycle: trig at cycle %0d, required cycle %0d", cyc, exp_cyc);
            end
         end
         checks++;
         if (prev_trig === 1'b1) begin
            failures++;
            $display("[TB] FAIL trig_consecutive: trig high at cycle %0d and previous cycle, required gap", cyc);
         end
      end
      if (exp_q.size() > 0 && exp_q[0] < cyc) begin
         checks++;
         failures++;
         $display("[TB] FAIL trig_missing: no trig at cycle %0d (now %0d), required trig", exp_q[0], cyc);
         exp_cyc = exp_q.pop_front();
      end
      prev_trig = trig;
   end

   task automatic tick(input logic [11:0] d);
      @(posedge clk);
      #1;
      d_in = d;
   endtask

   task automatic hold(input logic [11:0] d, input int n);
      for (int i = 0; i < n; i++) tick(d);
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      rst_n = 1'b0;
      hold(12'd100, 3);
      @(negedge clk);
      checks++; if (trig !== 1'b0) begin failures++; $display("[TB] FAIL rst_trig: got %b, want 0", trig); end
      checks++; if (baseline !== 12'd0) begin failures++; $display("[TB] FAIL rst_baseline: got %0d, want 0", baseline); end
      checks++; if (excess !== 13'd0) begin failures++; $display("[TB] FAIL rst_excess: got %0d, want 0", excess); end
      checks++; if (armed !== 1'b0) begin failures++; $display("[TB] FAIL rst_armed: got %b, want 0", armed); end
      checks++; if (trig_count !== 32'd0) begin failures++; $display("[TB] FAIL rst_count: got %0d, want 0", trig_count); end
      checks++; if (dut.state_q !== S_IDLE) begin failures++; $display("[TB] FAIL rst_state: got %0d, want S_IDLE", dut.state_q); end
      tick(12'd100);
      rst_n = 1'b1;
      hold(12'd100, 6);
      @(negedge clk);
      checks++; if (baseline !== 12'd100) begin failures++; $display("[TB] FAIL steady_baseline: got %0d, want 100", baseline); end
      checks++; if (excess !== 13'd0) begin failures++; $display("[TB] FAIL steady_excess: got %0d, want 0", excess); end
      checks++; if (armed !== 1'b1) begin failures++; $display("[TB] FAIL steady_armed: got %b, want 1", armed); end
   endtask

   task automatic test_threshold();
      logic [12:0] neg_exp;
      $display("[TB] test_threshold");
      tick(12'd120);
      hold(12'd100, 6);
      tick(12'd121);
      exp_q.push_back(cyc + STAGE_LATENCY);
      tick(12'd100);
      @(posedge clk);
      @(negedge clk);
      checks++; if (excess !== 13'd21) begin failures++; $display("[TB] FAIL excess_121: got %0d, want 21", excess); end
      hold(12'd100, 6);
      @(negedge clk);
      checks++; if (trig_count !== 32'd1) begin failures++; $display("[TB] FAIL count_after_first: got %0d, want 1", trig_count); end
      neg_exp = 13'd0 - 13'd10;
      tick(12'd90);
      tick(12'd100);
      @(posedge clk);
      @(negedge clk);
      checks++; if (excess !== neg_exp) begin failures++; $display("[TB] FAIL excess_negative: got %h, want %h", excess, neg_exp); end
      hold(12'd100, 4);
   endtask

   task automatic test_hysteresis();
      $display("[TB] test_hysteresis");
      hyst = 12'd5;
      holdoff_len = 16'd0;
      tick(12'd130);
      exp_q.push_back(cyc + STAGE_LATENCY);
      hold(12'd130, 9);
      hold(12'd115, 6);
      @(negedge clk);
      checks++; if (dut.state_q !== S_HIGH) begin failures++; $display("[TB] FAIL hyst_edge_state: got %0d, want S_HIGH", dut.state_q); end
      checks++; if (armed !== 1'b0) begin failures++; $display("[TB] FAIL hyst_edge_armed: got %b, want 0", armed); end
      hold(12'd130, 3);
      hold(12'd114, 5);
      @(negedge clk);
      checks++; if (armed !== 1'b1) begin failures++; $display("[TB] FAIL hyst_rearm: got %b, want 1", armed); end
      tick(12'd130);
      exp_q.push_back(cyc + STAGE_LATENCY);
      hold(12'd130, 3);
      hold(12'd100, 6);
      @(negedge clk);
      checks++; if (trig_count !== 32'd3) begin failures++; $display("[TB] FAIL count_after_hyst: got %0d, want 3", trig_count); end
   endtask

   task automatic test_holdoff();
      int c1;
      $display("[TB] test_holdoff");
      holdoff_len = 16'd8;
      tick(12'd130);
      exp_q.push_back(cyc + STAGE_LATENCY);
      hold(12'd130, 3);
      tick(12'd100);
      c1 = cyc;
      tick(12'd130);
      exp_q.push_back(c1 + 12);
      hold(12'd130, 4);
      @(posedge clk);
      @(negedge clk);
      checks++; if (dut.state_q !== S_HOLDOFF) begin failures++; $display("[TB] FAIL holdoff_state: got %0d, want S_HOLDOFF", dut.state_q); end
      checks++; if (armed !== 1'b0) begin failures++; $display("[TB] FAIL holdoff_armed: got %b, want 0", armed); end
      hold(12'd130, 12);
      hold(12'd100, 15);
      @(negedge clk);
      checks++; if (armed !== 1'b1) begin failures++; $display("[TB] FAIL holdoff_rearm: got %b, want 1", armed); end
      checks++; if (trig_count !== 32'd5) begin failures++; $display("[TB] FAIL count_after_holdoff: got %0d, want 5", trig_count); end
   endtask

   task automatic test_abort();
      $display("[TB] test_abort");
      tick(12'd130);
      exp_q.push_back(cyc + STAGE_LATENCY);
      hold(12'd130, 4);
      tick(12'd100);
      sum_valid = 1'b0;
      tick(12'd100);
      sum_valid = 1'b1;
      tick(12'd100);
      @(posedge clk);
      @(negedge clk);
      checks++; if (dut.state_q !== S_IDLE) begin failures++; $display("[TB] FAIL valid_drop_state: got %0d, want S_IDLE", dut.state_q); end
      hold(12'd100, 6);
      @(negedge clk);
      checks++; if (armed !== 1'b1) begin failures++; $display("[TB] FAIL valid_rearm: got %b, want 1", armed); end
      tick(12'd130);
      exp_q.push_back(cyc + STAGE_LATENCY);
      hold(12'd130, 4);
      tick(12'd100);
      enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (dut.state_q !== S_IDLE) begin failures++; $display("[TB] FAIL enable_drop_state: got %0d, want S_IDLE", dut.state_q); end
      hold(12'd100, 3);
      enable = 1'b1;
      hold(12'd100, 5);
      @(negedge clk);
      checks++; if (armed !== 1'b1) begin failures++; $display("[TB] FAIL enable_rearm: got %b, want 1", armed); end
   endtask

   task automatic test_reset_holdoff();
      int r;
      $display("[TB] test_reset_holdoff");
      tick(12'd130);
      exp_q.push_back(cyc + STAGE_LATENCY);
      hold(12'd130, 3);
      hold(12'd100, 5);
      @(posedge clk);
      @(negedge clk);
      checks++; if (dut.state_q !== S_HOLDOFF) begin failures++; $display("[TB] FAIL pre_reset_state: got %0d, want S_HOLDOFF", dut.state_q); end
      tick(12'd130);
      rst_n = 1'b0;
      hold(12'd130, 2);
      @(negedge clk);
      checks++; if (trig_count !== 32'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d, want 0", trig_count); end
      checks++; if (dut.state_q !== S_IDLE) begin failures++; $display("[TB] FAIL reset_state: got %0d, want S_IDLE", dut.state_q); end
      tick(12'd130);
      rst_n = 1'b1;
      r = cyc;
      exp_q.push_back(r + STAGE_LATENCY + 1);
      hold(12'd130, 6);
      hold(12'd100, 15);
      @(negedge clk);
      checks++; if (trig_count !== 32'd1) begin failures++; $display("[TB] FAIL count_after_reset: got %0d, want 1", trig_count); end
      checks++; if (armed !== 1'b1) begin failures++; $display("[TB] FAIL reset_rearm: got %b, want 1", armed); end
   endtask

   task automatic test_count_clr();
      $display("[TB] test_count_clr");
      holdoff_len = 16'd0;
      tick(12'd130);
      exp_q.push_back(cyc + STAGE_LATENCY);
      hold(12'd130, 2);
      tick(12'd130);
      count_clr = 1'b1;
      tick(12'd130);
      count_clr = 1'b0;
      @(negedge clk);
      checks++; if (trig_count !== 32'd1) begin failures++; $display("[TB] FAIL clr_with_trig: got %0d, want 1", trig_count); end
      hold(12'd100, 6);
      tick(12'd130);
      exp_q.push_back(cyc + STAGE_LATENCY);
      hold(12'd130, 2);
      tick(12'd130);
      force dut.trig_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.trig_count_q;
      tick(12'd130);
      @(negedge clk);
      checks++; if (trig_count !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL count_saturate: got %h, want ffffffff", trig_count); end
      hold(12'd100, 6);
      tick(12'd100);
      count_clr = 1'b1;
      tick(12'd100);
      count_clr = 1'b0;
      @(negedge clk);
      checks++; if (trig_count !== 32'd0) begin failures++; $display("[TB] FAIL clr_plain: got %0d, want 0", trig_count); end
   endtask

   task automatic test_sum_len();
      logic [12:0] neg_exp;
      $display("[TB] test_sum_len");
      neg_exp = 13'd0 - 13'd100;
      tick(12'd100);
      sum_len_log2 = 3'd6;
      @(posedge clk);
      @(negedge clk);
      checks++; if (baseline !== 12'd200) begin failures++; $display("[TB] FAIL len6_baseline: got %0d, want 200", baseline); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (excess !== neg_exp) begin failures++; $display("[TB] FAIL len6_excess: got %h, want %h", excess, neg_exp); end
      checks++; if (armed !== 1'b1) begin failures++; $display("[TB] FAIL len6_armed: got %b, want 1", armed); end
      tick(12'd100);
      sum_len_log2 = 3'd7;
      hold(12'd100, 4);
      @(negedge clk);
      checks++; if (baseline !== 12'd100) begin failures++; $display("[TB] FAIL len7_baseline: got %0d, want 100", baseline); end
   endtask

   initial begin
      rst_n        = 1'b0;
      d_in         = 12'd100;
      sum_in       = 19'd12800;
      sum_valid    = 1'b1;
      sum_len_log2 = 3'd7;
      enable       = 1'b1;
      threshold    = 12'd20;
      hyst         = 12'd5;
      holdoff_len  = 16'd0;
      count_clr    = 1'b0;

      test_reset();
      test_threshold();
      test_hysteresis();
      test_holdoff();
      test_abort();
      test_reset_holdoff();
      test_count_clr();
      test_sum_len();

      hold(12'd100, 5);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL pending_triggers: %0d still queued, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
